game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
Game-level consumer of the pipe subsystem's event outputs. It receives the one-clock pass pulses and the collision level from the pipe renderer, keeps the BCD score and high score, and runs the play/death/restart state machine. It drives the enable and world-reset that gate the pipe and bird movers. It sits between the input debouncer and the renderers/score display.

Parameters:
DEATH_HOLD_CYCLES, 50_000_000, clocks spent in DYING before GAME_OVER; legal range 1..2^26-1.
FLOOR_Y, 460, bird bottom edge at or below this row counts as a ground crash.
SCORE_MAX, 999, saturation value of score; must be ≤ 999 (3 BCD digits).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
flap_btn  in  1  debounced flap button level, synchronous to clk
pipe_passed  in  1  one-clock pulse per pipe crossing bird_x
pipe_collision  in  1  level, bird overlaps a pipe body
bird_y  in  10  bird top row
bird_h  in  5  bird height
game_enable  out  1  high only in PLAYING; gates pipe/bird motion
world_reset  out  1  one-clock pulse that re-seeds pipes and bird at game start
state  out  2  0=IDLE, 1=PLAYING, 2=DYING, 3=GAME_OVER
score_bcd  out  12  current score, 3 BCD digits, [11:8] hundreds
high_bcd  out  12  best score since reset, BCD
new_high  out  1  high while in GAME_OVER if the last game set a new high score
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (async, any state, mid-game included): state=IDLE, score_bcd=0, high_bcd=0, new_high=0, world_reset=0, hold counter=0, flap edge register=1. This blocks a false edge if the button is held through reset.
- All outputs come from registers. game_enable and game_over decode the state register combinationally, so they have 0 extra latency versus state.
- Flap edge: flap_rise = flap_btn & ~flap_q. flap_q is registered every cycle.
- IDLE: game_enable=0. On flap_rise:
  - world_reset=1 for exactly the next cycle.
  - score_bcd<=0, new_high<=0.
  - state<=PLAYING on that same edge.
- PLAYING: game_enable=1.
  - A pipe_passed pulse increments score by 1 in BCD: digit 9 wraps to 0 with carry. Score stays at SCORE_MAX once reached, with no wrap to 0.
  - crash = pipe_collision | ({1'b0,bird_y}+bird_h >= FLOOR_Y), computed at 11-bit width.
  - On crash: state<=DYING and hold counter<=0.
  - Pass and crash in the same cycle: the pass still counts, then DYING.
  - flap_rise is ignored in PLAYING; the bird module consumes the button directly.
- DYING: game_enable=0. The hold counter increments every cycle. pipe_passed, pipe_collision and flap are ignored.
  - When counter == DEATH_HOLD_CYCLES-1: state<=GAME_OVER.
  - On that same edge, if score_bcd > high_bcd: high_bcd<=score_bcd and new_high<=1. Digit-wise BCD compare equals numeric compare.
  - Equal score does not set new_high.
- GAME_OVER: game_enable=0, game_over=1. score_bcd and high_bcd are held. On flap_rise, the action is identical to IDLE (world_reset pulse, clear score and new_high, go to PLAYING).
- Illegal state encodings cannot occur with 4 states in 2 bits. The default branch goes to IDLE.
- pipe_passed outside PLAYING is dropped, never queued.
- A held flap_btn produces one flap_rise only; the button must be released and re-pressed to restart.

Test Plan:
- Use DEATH_HOLD_CYCLES=4 for all scenarios.
- Reset then flap press: world_reset high exactly 1 cycle, state=1, game_enable=1, score_bcd=0x000.
- In PLAYING, 12 pipe_passed pulses spaced 3 cycles apart: score_bcd=0x012. Preload to 0x099 plus 1 pulse → 0x100. At 0x999 plus 1 pulse → stays 0x999.
- Collision at score 0x005: state=2 next cycle, game_enable=0, 4 cycles later state=3, high_bcd=0x005, new_high=1. Pulses sent during DYING leave score at 0x005.
- Second game reaching 0x003 then bird_y=450, bird_h=10 (floor crash): GAME_OVER with high_bcd=0x005 and new_high=0. A rerun ending at 0x005 also gives new_high=0.
- pipe_passed and pipe_collision in the same cycle at score 0x007: score_bcd=0x008 and state=DYING.
- Flap held through reset then kept high: no restart. Release then press: restart. Assert reset during DYING: immediate IDLE with all outputs 0, including high_bcd.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Game-level sequencer: IDLE/PLAYING/DYING/GAME_OVER with BCD score and high-score tracking.
// Consumes pipe pass/collision events and drives the movers' enable and world reset.
module game_state_ctrl #(
   parameter int unsigned DEATH_HOLD_CYCLES = 50_000_000,
   parameter int unsigned FLOOR_Y           = 460,
   parameter int unsigned SCORE_MAX         = 999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flap_btn,
   input  logic        pipe_passed,
   input  logic        pipe_collision,
   input  logic [9:0]  bird_y,
   input  logic [4:0]  bird_h,
   output logic        game_enable,
   output logic        world_reset,
   output logic [1:0]  state,
   output logic [11:0] score_bcd,
   output logic [11:0] high_bcd,
   output logic        new_high,
   output logic        game_over
);

   // state       | meaning
   // S_IDLE      | power-up, waiting for first flap
   // S_PLAYING   | world moving, scoring passes, watching for crash
   // S_DYING     | frozen for DEATH_HOLD_CYCLES, inputs ignored
   // S_GAME_OVER | score shown, high score settled, flap restarts
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PLAYING   = 2'd1,
      S_DYING     = 2'd2,
      S_GAME_OVER = 2'd3
   } state_t;

   localparam logic [11:0] SCORE_MAX_BCD = {4'(SCORE_MAX / 100),
                                            4'((SCORE_MAX / 10) % 10),
                                            4'(SCORE_MAX % 10)};
   localparam logic [25:0] HOLD_LAST     = 26'(DEATH_HOLD_CYCLES - 1);
   localparam logic [10:0] FLOOR_Y_W     = 11'(FLOOR_Y);

   state_t      state_q;
   logic [11:0] score_q;
   logic [11:0] high_q;
   logic        new_high_q;
   logic        world_reset_q;
   logic [25:0] hold_q;
   logic        flap_q;

   logic        flap_rise;
   logic [10:0] bird_bottom;
   logic        crash;
   logic [11:0] score_inc_d;

   assign flap_rise   = flap_btn & ~flap_q;
   assign bird_bottom = {1'b0, bird_y} + {6'd0, bird_h};
   assign crash       = pipe_collision | (bird_bottom >= FLOOR_Y_W);

   // BCD +1 with per-digit carry, pinned at SCORE_MAX
   always_comb begin
      score_inc_d = score_q;
      if (score_q < SCORE_MAX_BCD) begin
         if (score_q[3:0] == 4'd9) begin
            score_inc_d[3:0] = 4'd0;
            if (score_q[7:4] == 4'd9) begin
               score_inc_d[7:4]  = 4'd0;
               score_inc_d[11:8] = score_q[11:8] + 4'd1;
            end else begin
               score_inc_d[7:4] = score_q[7:4] + 4'd1;
            end
         end else begin
            score_inc_d[3:0] = score_q[3:0] + 4'd1;
         end
      end
   end

   // flap_q resets high so a button held through reset cannot start a game
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         score_q       <= '0;
         high_q        <= '0;
         new_high_q    <= 1'b0;
         world_reset_q <= 1'b0;
         hold_q        <= '0;
         flap_q        <= 1'b1;
      end else begin
         flap_q        <= flap_btn;
         world_reset_q <= 1'b0;
         case (state_q)
            S_IDLE, S_GAME_OVER: begin
               if (flap_rise) begin
                  world_reset_q <= 1'b1;
                  score_q       <= '0;
                  new_high_q    <= 1'b0;
                  state_q       <= S_PLAYING;
               end
            end
            S_PLAYING: begin
               if (pipe_passed) score_q <= score_inc_d;
               if (crash) begin
                  state_q <= S_DYING;
                  hold_q  <= '0;
               end
            end
            S_DYING: begin
               hold_q <= hold_q + 26'd1;
               if (hold_q == HOLD_LAST) begin
                  state_q <= S_GAME_OVER;
                  if (score_q > high_q) begin
                     high_q     <= score_q;
                     new_high_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign state       = state_q;
   assign score_bcd   = score_q;
   assign high_bcd    = high_q;
   assign new_high    = new_high_q;
   assign world_reset = world_reset_q;
   assign game_enable = (state_q == S_PLAYING);
   assign game_over   = (state_q == S_GAME_OVER);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed/randomized bench for game_state_ctrl; score and high score are tracked as plain
// integers and converted to BCD only when compared.
module tb_game_state_ctrl;

   localparam int DH = 4;
   localparam int SMAX = 999;
   localparam int FLOOR = 460;

   logic        clk = 1'b0;
   logic        reset;
   logic        flap_btn;
   logic        pipe_passed;
   logic        pipe_collision;
   logic [9:0]  bird_y;
   logic [4:0]  bird_h;
   logic        game_enable;
   logic        world_reset;
   logic [1:0]  state;
   logic [11:0] score_bcd;
   logic [11:0] high_bcd;
   logic        new_high;
   logic        game_over;

   int checks = 0;
   int failures = 0;
   int m_score = 0;
   int m_high = 0;
   int m_new = 0;

   game_state_ctrl #(.DEATH_HOLD_CYCLES(DH), .FLOOR_Y(FLOOR), .SCORE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset), .flap_btn(flap_btn), .pipe_passed(pipe_passed),
      .pipe_collision(pipe_collision), .bird_y(bird_y), .bird_h(bird_h),
      .game_enable(game_enable), .world_reset(world_reset), .state(state),
      .score_bcd(score_bcd), .high_bcd(high_bcd), .new_high(new_high), .game_over(game_over)
   );

   always #5 clk = ~clk;

   function automatic int to_bcd(int v);
      return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic safe_bird();
      bird_h = 5'($urandom_range(1, 31));
      bird_y = 10'($urandom_range(0, FLOOR - 1 - int'(bird_h)));
   endtask

   task automatic start_game();
      flap_btn = 1'b0;
      tick();
      flap_btn = 1'b1;
      tick();
      m_score = 0;
      m_new = 0;
      chk("start_world_reset", int'(world_reset), 1);
      chk("start_state", int'(state), 1);
      chk("start_enable", int'(game_enable), 1);
      chk("start_score", int'(score_bcd), 0);
      tick();
      chk("start_world_reset_drop", int'(world_reset), 0);
      flap_btn = 1'b0;
   endtask

   task automatic pass(int gap);
      pipe_passed = 1'b1;
      tick();
      pipe_passed = 1'b0;
      m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
      repeat (gap) tick();
   endtask

   // called one cycle after the crash edge; runs out the hold and checks the result
   task automatic finish_death(string tag);
      chk({tag, "_dying"}, int'(state), 2);
      chk({tag, "_dying_en"}, int'(game_enable), 0);
      pipe_passed = 1'b1;
      pipe_collision = 1'b1;
      flap_btn = 1'b1;
      tick();
      pipe_passed = 1'b0;
      pipe_collision = 1'b0;
      flap_btn = 1'b0;
      repeat (DH - 2) tick();
      chk({tag, "_still_dying"}, int'(state), 2);
      tick();
      if (m_score > m_high) begin
         m_high = m_score;
         m_new = 1;
      end else begin
         m_new = 0;
      end
      chk({tag, "_over_state"}, int'(state), 3);
      chk({tag, "_over_flag"}, int'(game_over), 1);
      chk({tag, "_score"}, int'(score_bcd), to_bcd(m_score));
      chk({tag, "_high"}, int'(high_bcd), to_bcd(m_high));
      chk({tag, "_new_high"}, int'(new_high), m_new);
   endtask

   task automatic collide();
      pipe_collision = 1'b1;
      tick();
      pipe_collision = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      flap_btn = 1'b0;
      pipe_passed = 1'b0;
      pipe_collision = 1'b0;
      bird_y = 10'd100;
      bird_h = 5'd10;
      repeat (3) tick();
      chk("rst_state", int'(state), 0);
      chk("rst_score", int'(score_bcd), 0);
      chk("rst_high", int'(high_bcd), 0);
      chk("rst_new_high", int'(new_high), 0);
      chk("rst_world_reset", int'(world_reset), 0);
      chk("rst_enable", int'(game_enable), 0);
      chk("rst_game_over", int'(game_over), 0);
      reset = 1'b0;
      tick();

      // counting and BCD carries up to saturation
      start_game();
      safe_bird();
      for (int i = 0; i < 12; i++) pass(2);
      chk("score_12", int'(score_bcd), to_bcd(m_score));
      chk("score_12_const", int'(score_bcd), 'h012);
      while (m_score < 99) pass($urandom_range(0, 2));
      chk("score_99", int'(score_bcd), 'h099);
      pass(1);
      chk("score_100", int'(score_bcd), 'h100);
      while (m_score < 537) pass($urandom_range(0, 1));
      chk("score_mid", int'(score_bcd), to_bcd(m_score));
      while (m_score < SMAX) pass(0);
      chk("score_999", int'(score_bcd), 'h999);
      pass(1);
      chk("score_sat", int'(score_bcd), 'h999);
      chk("still_playing", int'(state), 1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_high = 0;
      chk("rst2_high", int'(high_bcd), 0);

      // first game: collision at 5 sets a new high
      start_game();
      for (int i = 0; i < 5; i++) pass($urandom_range(0, 3));
      collide();
      finish_death("g1");
      chk("g1_high_const", int'(high_bcd), 'h005);
      pass(1);
      chk("g1_drop_in_over", int'(score_bcd), 'h005);

      // second game: floor boundary, then floor crash at 3
      start_game();
      for (int i = 0; i < 3; i++) pass($urandom_range(0, 3));
      bird_h = 5'd10;
      bird_y = 10'd449;
      tick();
      chk("floor_459_no_crash", int'(state), 1);
      bird_y = 10'd450;
      tick();
      bird_y = 10'd100;
      finish_death("g2");
      chk("g2_new_high_const", int'(new_high), 0);

      // third game: tie with high score
      start_game();
      for (int i = 0; i < 5; i++) pass($urandom_range(0, 3));
      collide();
      finish_death("g3");

      // fourth game: pass and collision on the same edge at 7
      start_game();
      for (int i = 0; i < 7; i++) pass($urandom_range(0, 3));
      pipe_passed = 1'b1;
      pipe_collision = 1'b1;
      tick();
      pipe_passed = 1'b0;
      pipe_collision = 1'b0;
      m_score = m_score + 1;
      chk("same_cycle_score", int'(score_bcd), 'h008);
      finish_death("g4");

      // flap held through reset must not start a game
      flap_btn = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_high = 0;
      repeat (3) tick();
      chk("held_flap_idle", int'(state), 0);
      chk("held_flap_no_wr", int'(world_reset), 0);
      start_game();

      // async reset in DYING
      pass(1);
      collide();
      chk("pre_rst_dying", int'(state), 2);
      #2;
      reset = 1'b1;
      #1;
      chk("async_state", int'(state), 0);
      chk("async_score", int'(score_bcd), 0);
      chk("async_high", int'(high_bcd), 0);
      chk("async_enable", int'(game_enable), 0);
      chk("async_over", int'(game_over), 0);
      chk("async_new_high", int'(new_high), 0);
      tick();
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
